// File: rtl/blink_pkg.sv
// Frame format and receiver state encoding shared by blink, blink_rx and their benches.
package blink_pkg;

    localparam int DEF_BIT_CYCLES = 16;
    localparam int DEF_DATA_W     = 8;

    // Line levels framing each word; data bits travel MSB first.
    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;
    localparam bit   MSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_LO = 3'd4
    } rx_state_t;

endpackage

// File: rtl/blink_rx_if.sv
// Word output channel of blink_rx.
// Handshake: data_out is held stable while data_valid=1; a word is consumed at
// the rising clk edge where data_valid and data_ready are both 1.
interface blink_rx_if #(parameter int DATA_W = 8) ();

    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);

endinterface

// File: rtl/blink_sync.sv
// Two-flop synchronizer for the blink line plus a rising-edge strobe on the synced level.
module blink_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s2_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s2_d;

endmodule

// File: rtl/blink_rx.sv
// Receiver for the blink serial line: frame decoder FSM feeding a one-entry
// valid/ready output buffer. Decoding never waits for the consumer.
module blink_rx
    import blink_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      blink_in,
    blink_rx_if.master rx,
    output logic      frame_err,
    output logic      overrun,
    output rx_state_t fsm_state
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    logic line;
    logic rise;

    blink_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (blink_in),
        .level (line),
        .rise  (rise)
    );

    rx_state_t         state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic              deliver, deliver_nx;
    logic              err_nx;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            deliver   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            idx       <= idx_nx;
            shreg     <= shreg_nx;
            deliver   <= deliver_nx;
            frame_err <= err_nx;
        end
    end

    // Start is confirmed at its centre; every later bit is sampled one full
    // bit time after the previous sample, i.e. also at its centre.
    always_comb begin
        state_nx   = state;
        cnt_nx     = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        idx_nx     = idx;
        shreg_nx   = shreg;
        deliver_nx = 1'b0;
        err_nx     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (rise) state_nx = START;
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = (line == START_LVL) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    shreg_nx = (shreg << 1) | DATA_W'(line);
                    idx_nx   = idx + 1'b1;
                    if (idx == IDX_LAST) state_nx = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    if (line == STOP_LVL) begin
                        deliver_nx = 1'b1;
                        state_nx   = IDLE;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = WAIT_LO;
                    end
                end
            end
            WAIT_LO: begin
                cnt_nx = '0;
                if (!line) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A new word may replace the buffered one only if that one leaves this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver) begin
                if (!valid_q || rx.data_ready) begin
                    data_q  <= shreg;
                    valid_q <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_q && rx.data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.data_out   = data_q;
    assign rx.data_valid = valid_q;
    assign fsm_state     = state;

endmodule
